// File: rtl/rh_fetch_ctrl.sv
// Fetch sequencer: credit-limited in-order instruction reads, a small FWFT
// instruction buffer toward issue, and redirect flush with stale-response drop.
module rh_fetch_ctrl #(
   parameter int             AW       = 32,
   parameter int             DW       = 32,
   parameter int             DEPTH    = 4,
   parameter logic [AW-1:0]  PC_RESET = '0
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          fetch_en,
   input  logic          redir_valid,
   input  logic [AW-1:0] redir_pc,
   output logic          req_valid,
   input  logic          req_ready,
   output logic [AW-1:0] req_addr,
   input  logic          rsp_valid,
   input  logic [DW-1:0] rsp_data,
   output logic          iss_valid,
   input  logic          iss_ready,
   output logic [DW-1:0] iss_instr,
   output logic [AW-1:0] iss_pc,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // req_valid/req_addr may change while req_ready=0; rsp_valid has no ready
   // and is always taken; iss_valid stays up until the head is popped or flushed.

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_rsp_pc;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [DW-1:0] r_instr_mem [DEPTH];
   logic [AW-1:0] r_pc_mem    [DEPTH];

   logic          w_credit;
   logic          w_req_fire;
   logic          w_pop;
   logic          w_drop;
   logic          w_push;
   logic [CW-1:0] w_out_nxt;

   // Buffered plus in-flight never exceeds DEPTH, so a push can never overflow.
   assign w_credit   = ({1'b0, r_out} + {1'b0, r_cnt}) < DEPTH_W;
   assign req_valid  = (r_state == S_RUN) && w_credit;
   assign req_addr   = r_pc;
   assign w_req_fire = req_valid && req_ready;

   assign iss_valid  = (r_cnt != '0);
   assign iss_instr  = r_instr_mem[r_rd];
   assign iss_pc     = r_pc_mem[r_rd];
   assign w_pop      = iss_valid && iss_ready;

   assign w_drop     = (r_discard != '0) || redir_valid;
   assign w_push     = rsp_valid && !w_drop;
   assign w_out_nxt  = r_out + CW'(w_req_fire) - CW'(rsp_valid);

   assign busy       = (r_state != S_IDLE) || (r_out != '0);
   assign dbg_state  = r_state;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (fetch_en) w_state_nxt = S_RUN;
         S_RUN:   if (!fetch_en) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (fetch_en)
               w_state_nxt = S_RUN;
            else if (r_out == '0)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc      <= PC_RESET;
         r_rsp_pc  <= PC_RESET;
         r_out     <= '0;
         r_discard <= '0;
         r_cnt     <= '0;
         r_wr      <= '0;
         r_rd      <= '0;
      end else begin
         r_out <= w_out_nxt;

         if (redir_valid)
            r_pc <= redir_pc;
         else if (w_req_fire)
            r_pc <= r_pc + AW'(4);

         // Everything issued up to and including the redirect cycle is stale.
         if (redir_valid) begin
            r_discard <= w_out_nxt;
            r_rsp_pc  <= redir_pc;
            r_cnt     <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
         end else begin
            if (rsp_valid && (r_discard != '0))
               r_discard <= r_discard - CW'(1);
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + AW'(4);
               r_wr     <= r_wr + PW'(1);
            end
            if (w_pop)
               r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_instr_mem[i] <= '0;
            r_pc_mem[i]    <= '0;
         end
      end else if (w_push) begin
         r_instr_mem[r_wr] <= rsp_data;
         r_pc_mem[r_wr]    <= r_rsp_pc;
      end
   end

endmodule

// File: tb/tb_rh_fetch_ctrl.sv
// Directed bench for rh_fetch_ctrl: behavioural memory with fixed latency,
// issue scoreboard on an expected-PC queue, hand-computed address checks.
module tb_rh_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        fetch_en, redir_valid, req_ready, rsp_valid, iss_ready;
   logic [31:0] redir_pc, rsp_data;

   logic        req_valid_a, iss_valid_a, busy_a;
   logic [31:0] req_addr_a, iss_instr_a, iss_pc_a;
   logic [1:0]  state_a;
   logic        req_valid_w, iss_valid_w, busy_w;
   logic [31:0] req_addr_w, iss_instr_w, iss_pc_w;
   logic [1:0]  state_w;

   logic        sel_w;
   logic        m_req_valid, m_iss_valid, m_busy;
   logic [31:0] m_req_addr, m_iss_instr, m_iss_pc;
   logic [1:0]  m_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc;
   int          mem_lat;
   logic        mem_rdy;
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   rh_fetch_ctrl dut_a (
      .clk(clk), .rstn(rstn), .fetch_en(fetch_en),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .req_valid(req_valid_a), .req_ready(req_ready), .req_addr(req_addr_a),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .iss_valid(iss_valid_a), .iss_ready(iss_ready),
      .iss_instr(iss_instr_a), .iss_pc(iss_pc_a),
      .busy(busy_a), .dbg_state(state_a)
   );

   rh_fetch_ctrl #(.PC_RESET(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rstn(rstn), .fetch_en(fetch_en),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .req_valid(req_valid_w), .req_ready(req_ready), .req_addr(req_addr_w),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .iss_valid(iss_valid_w), .iss_ready(iss_ready),
      .iss_instr(iss_instr_w), .iss_pc(iss_pc_w),
      .busy(busy_w), .dbg_state(state_w)
   );

   assign m_req_valid = sel_w ? req_valid_w : req_valid_a;
   assign m_req_addr  = sel_w ? req_addr_w  : req_addr_a;
   assign m_iss_valid = sel_w ? iss_valid_w : iss_valid_a;
   assign m_iss_instr = sel_w ? iss_instr_w : iss_instr_a;
   assign m_iss_pc    = sel_w ? iss_pc_w    : iss_pc_a;
   assign m_busy      = sel_w ? busy_w      : busy_a;
   assign m_state     = sel_w ? state_w     : state_a;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5EED_C0DE;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive memory, score the issue pop, advance to the next negedge.
   task automatic step();
      logic [31:0] e;
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = instr_of(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
      req_ready = mem_rdy;
      if (m_req_valid && req_ready) begin
         mem_addr_q.push_back(m_req_addr);
         mem_due_q.push_back(cyc + mem_lat);
      end
      if (m_iss_valid && iss_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("iss_extra", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check_eq("iss_pc", m_iss_pc, e);
            check_eq("iss_instr", m_iss_instr, instr_of(e));
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      redir_valid = 1'b0;
   endtask

   task automatic do_reset(input logic w);
      rstn = 1'b0;
      fetch_en = 0; redir_valid = 0; redir_pc = '0;
      req_ready = 0; rsp_valid = 0; rsp_data = '0; iss_ready = 0;
      mem_rdy = 1'b1; mem_lat = 1; sel_w = w;
      mem_addr_q.delete(); mem_due_q.delete(); exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      cyc = 0;
   endtask

   task automatic run_until_empty(input string tag, input int budget);
      int b;
      b = budget;
      while (exp_q.size() > 0 && b > 0) begin
         step();
         b--;
      end
      check_eq(tag, exp_q.size(), 0);
   endtask

   initial begin
      logic [31:0] wrap_addr[4];
      wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      // Reset values
      do_reset(1'b0);
      check_eq("rst_req_valid", req_valid_a, 0);
      check_eq("rst_iss_valid", iss_valid_a, 0);
      check_eq("rst_busy",      busy_a, 0);
      check_eq("rst_req_addr",  req_addr_a, 32'h0);
      check_eq("rst_iss_instr", iss_instr_a, 32'h0);
      check_eq("rst_iss_pc",    iss_pc_a, 32'h0);
      check_eq("rst_state",     state_a, 0);
      check_eq("rst_w_req_addr", req_addr_w, 32'hFFFF_FFF8);

      // Streaming fetch: one request and one issue per cycle once filled
      iss_ready = 1; fetch_en = 1;
      for (int k = 0; k <= 10; k++) exp_q.push_back(32'(4 * k));
      check_eq("t1_idle_no_req", m_req_valid, 0);
      step();
      for (int k = 0; k < 10; k++) begin
         check_eq("t1_req_valid", m_req_valid, 1);
         check_eq("t1_req_addr", m_req_addr, 32'(4 * k));
         if (k >= 2) check_eq("t1_iss_gapless", m_iss_valid, 1);
         step();
      end
      fetch_en = 0;
      step();
      repeat (6) step();
      check_eq("t1_all_issued", exp_q.size(), 0);
      check_eq("t1_busy_end", m_busy, 0);
      check_eq("t1_state_end", m_state, 0);

      // Credit limit with issue stalled
      do_reset(1'b0);
      fetch_en = 1; iss_ready = 0;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      step();
      for (int k = 0; k < 4; k++) begin
         check_eq("t2_req_valid", m_req_valid, 1);
         check_eq("t2_req_addr", m_req_addr, 32'(4 * k));
         step();
      end
      for (int k = 0; k < 3; k++) begin
         check_eq("t2_credit_stall", m_req_valid, 0);
         step();
      end
      check_eq("t2_full_head", m_iss_pc, 32'h0);
      iss_ready = 1;
      step();
      iss_ready = 0;
      check_eq("t2_one_more_valid", m_req_valid, 1);
      check_eq("t2_one_more_addr", m_req_addr, 32'h10);
      step();
      for (int k = 0; k < 3; k++) begin
         check_eq("t2_stall_again", m_req_valid, 0);
         step();
      end
      check_eq("t2_head_after_pop", m_iss_pc, 32'h4);

      // Redirect with three outstanding and a fire in the same cycle
      do_reset(1'b0);
      mem_lat = 4; fetch_en = 1; iss_ready = 1;
      for (int k = 0; k < 8; k++) exp_q.push_back(32'h100 + 32'(4 * k));
      step();
      for (int k = 0; k < 3; k++) begin
         check_eq("t3_req_addr", m_req_addr, 32'(4 * k));
         step();
      end
      check_eq("t3_fire_c_valid", m_req_valid, 1);
      check_eq("t3_fire_c_addr", m_req_addr, 32'hC);
      redir_valid = 1; redir_pc = 32'h100;
      step();
      check_eq("t3_redir_addr", m_req_addr, 32'h100);
      check_eq("t3_discard", dut_a.r_discard, 4);
      check_eq("t3_iss_empty", m_iss_valid, 0);
      run_until_empty("t3_all_issued", 60);

      // Redirect coincident with a response and an issue pop, two buffered
      do_reset(1'b0);
      mem_lat = 2; fetch_en = 1; iss_ready = 0;
      exp_q = '{32'h0, 32'h200, 32'h204, 32'h208};
      step();
      for (int k = 0; k < 4; k++) begin
         check_eq("t4_req_addr", m_req_addr, 32'(4 * k));
         step();
      end
      check_eq("t4_pre_iss_valid", m_iss_valid, 1);
      check_eq("t4_pre_iss_pc", m_iss_pc, 32'h0);
      check_eq("t4_pre_credit", m_req_valid, 0);
      redir_valid = 1; redir_pc = 32'h200; iss_ready = 1;
      step();
      check_eq("t4_flushed", m_iss_valid, 0);
      check_eq("t4_discard", dut_a.r_discard, 1);
      check_eq("t4_redir_addr", m_req_addr, 32'h200);
      run_until_empty("t4_all_issued", 40);

      // fetch_en dropped with two outstanding
      do_reset(1'b0);
      mem_lat = 2; fetch_en = 1; iss_ready = 1;
      exp_q = '{32'h0, 32'h4};
      step();
      check_eq("t5_req0", m_req_addr, 32'h0);
      step();
      check_eq("t5_req1", m_req_addr, 32'h4);
      fetch_en = 0;
      step();
      check_eq("t5_no_req_a", m_req_valid, 0);
      check_eq("t5_busy_a", m_busy, 1);
      check_eq("t5_state_drain", m_state, 2);
      step();
      check_eq("t5_no_req_b", m_req_valid, 0);
      step();
      check_eq("t5_busy_last", m_busy, 1);
      check_eq("t5_state_drain_last", m_state, 2);
      step();
      check_eq("t5_busy_low", m_busy, 0);
      check_eq("t5_state_idle", m_state, 0);
      check_eq("t5_no_req_c", m_req_valid, 0);
      check_eq("t5_all_issued", exp_q.size(), 0);

      // PC wrap from a high reset PC
      do_reset(1'b1);
      check_eq("t6_reset_pc", m_req_addr, 32'hFFFF_FFF8);
      check_eq("t6_reset_valid", m_req_valid, 0);
      fetch_en = 1; iss_ready = 1;
      for (int k = 0; k < 4; k++) exp_q.push_back(wrap_addr[k]);
      step();
      for (int k = 0; k < 4; k++) begin
         check_eq("t6_req_valid", m_req_valid, 1);
         check_eq("t6_req_addr", m_req_addr, wrap_addr[k]);
         if (k == 3) fetch_en = 0;
         step();
      end
      run_until_empty("t6_all_issued", 20);
      check_eq("t6_busy_end", m_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
